// File: rtl/adder_stream_pkg.sv
// Shared definitions for the adder stream accumulator slice.
//   state_t           : accumulator FSM states
//   DEFAULT_ACC_W     : default accumulator / result width
//   DEFAULT_BURST_LEN : default number of pair sums per burst
//   ADDER_W           : operand and pair-sum width of adder_32bit
package adder_stream_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   localparam int DEFAULT_ACC_W     = 40;
   localparam int DEFAULT_BURST_LEN = 16;
   localparam int ADDER_W           = 32;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit modular adder.
//   a, b : operands
//   sum  : (a + b) mod 2^32; the carry out of bit 31 is not produced
module adder_32bit
   import adder_stream_pkg::*;
(
   input  logic [ADDER_W-1:0] a,
   input  logic [ADDER_W-1:0] b,
   output logic [ADDER_W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/adder_stream_accum.sv
// Burst accumulator for a stream of 32-bit operand pairs.
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid/in_ready, in_a, in_b  : operand pair handshake
//   flush                          : close the current burst early
//   out_valid/out_ready            : burst result handshake
//   out_data, out_count, out_ovf   : burst total, beat count, overflow flag
module adder_stream_accum
   import adder_stream_pkg::*;
#(
   parameter  int ACC_W     = DEFAULT_ACC_W,
   parameter  int BURST_LEN = DEFAULT_BURST_LEN,
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_a,
   input  logic [31:0]        in_b,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_data,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_ovf
);

   if (ACC_W < ADDER_W + 1) begin : g_bad_acc_w
      $error("adder_stream_accum: ACC_W must be >= 33");
   end
   if (BURST_LEN < 1) begin : g_bad_burst_len
      $error("adder_stream_accum: BURST_LEN must be >= 1");
   end

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [ADDER_W-1:0] pair_sum;
   logic [ACC_W:0]     acc_sum;
   logic [CNT_W-1:0]   count_inc;
   logic               accept;

   adder_32bit u_adder (
      .a   (in_a),
      .b   (in_b),
      .sum (pair_sum)
   );

   assign accept    = in_valid && in_ready_q;
   // One extra bit captures the carry out of the ACC_W-bit add for ovf.
   assign acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(pair_sum);
   assign count_inc = count_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_d   = acc_sum[ACC_W-1:0];
               count_d = count_inc;
               ovf_d   = ovf_q | acc_sum[ACC_W];
               // A coincident flush still includes this beat.
               if (count_inc == CNT_W'(BURST_LEN) || flush) begin
                  state_d = DONE;
               end else begin
                  state_d = ACCUM;
               end
            end else if (flush && state_q == ACCUM) begin
               // Only a non-empty burst may be flushed, so no empty results.
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake flags are registered from the next state so they line up
      // with the registered result fields.
      in_ready_d  = (state_d != DONE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_stream_accum.sv
// Self-checking bench for adder_stream_accum (ACC_W=33, BURST_LEN=4).
// The reference model keeps the accepted pair sums of the open burst in a
// queue and derives total, count and overflow from plain arithmetic.
module tb_adder_stream_accum;

   localparam int ACC_W = 33;
   localparam int BL    = 4;
   localparam int CW    = $clog2(BL + 1);

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CW-1:0]    out_count;
   logic             out_ovf;

   adder_stream_accum #(
      .ACC_W     (ACC_W),
      .BURST_LEN (BL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   longint unsigned beats[$];
   bit              m_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned burst_total();
      longint unsigned t = 0;
      foreach (beats[i]) t += beats[i];
      return t;
   endfunction

   task automatic check_model();
      longint unsigned t;
      chk("in_ready", 64'(in_ready), 64'(!m_done));
      chk("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done) begin
         t = burst_total();
         chk("out_data", 64'(out_data), t & ((64'd1 << ACC_W) - 1));
         chk("out_count", 64'(out_count), 64'(beats.size()));
         chk("out_ovf", 64'(out_ovf), 64'(t >= (64'd1 << ACC_W)));
      end
   endtask

   // One clock cycle: check the presented state, drive inputs, advance model.
   task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit f, input bit ordy);
      logic [31:0] s;
      @(negedge clk);
      check_model();
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      flush     = f;
      out_ready = ordy;
      if (m_done) begin
         if (ordy) begin
            beats.delete();
            m_done = 1'b0;
         end
      end else begin
         if (v) begin
            s = a + b;
            beats.push_back(64'(s));
         end
         if (beats.size() == BL || (f && beats.size() > 0)) m_done = 1'b1;
      end
   endtask

   // Result presented right after the edge that consumes the last step.
   task automatic expect_result(input string tag, input logic [63:0] d,
                                input logic [63:0] c, input logic [63:0] o);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"}, 64'(out_data), d);
      chk({tag, "_count"}, 64'(out_count), c);
      chk({tag, "_ovf"}, 64'(out_ovf), o);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, 64'(out_data), 64'd0);
      chk({tag, "_out_count"}, 64'(out_count), 64'd0);
      chk({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #2;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic burst: 1+2+3+4+5+6+7+8 = 36.
      step(1, 1, 2, 0, 1);
      step(1, 3, 4, 0, 1);
      step(1, 5, 6, 0, 1);
      step(1, 7, 8, 0, 1);
      expect_result("basic", 36, 4, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // Pair sums wrap at 32 bits without flagging overflow.
      for (int i = 0; i < 4; i++) step(1, 32'hFFFF_FFFF, 32'h2, 0, 1);
      expect_result("pairwrap", 4, 4, 0);
      step(0, 0, 0, 0, 1);

      // Accumulator carry out of 33 bits sets ovf.
      for (int i = 0; i < 4; i++) step(1, 32'hFFFF_FFFF, 32'h0, 0, 1);
      expect_result("accovf", 64'h1_FFFF_FFFC, 4, 1);
      step(0, 0, 0, 0, 1);

      // Backpressure: result held, beats refused, then next burst from zero.
      for (int i = 0; i < 4; i++) step(1, 32'(i + 1), 32'(i + 1), 0, 0);
      expect_result("bp", 20, 4, 0);
      for (int i = 0; i < 5; i++) step(1, $urandom, $urandom, 0, 0);
      step(1, 9, 9, 0, 1);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
      expect_result("bpnext", 4, 4, 0);
      step(0, 0, 0, 0, 1);

      // Flush with no beat after two beats.
      step(1, 10, 0, 0, 1);
      step(1, 20, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      expect_result("flush", 30, 2, 0);
      step(0, 0, 0, 0, 1);

      // Flush coincident with a beat.
      step(1, 1, 0, 0, 1);
      step(1, 5, 0, 1, 1);
      expect_result("flushbeat", 6, 2, 0);
      step(0, 0, 0, 0, 1);

      // Flush in IDLE with a beat gives a one-beat burst.
      step(1, 7, 0, 1, 1);
      expect_result("flushidle1", 7, 1, 0);
      step(0, 0, 0, 0, 1);

      // Flush alone in IDLE is ignored.
      step(0, 0, 0, 1, 1);
      @(posedge clk);
      #1;
      chk("flushempty_valid", 64'(out_valid), 64'd0);
      step(0, 0, 0, 0, 1);

      // Asynchronous reset mid-burst.
      step(1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      @(negedge clk);
      #2;
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b1;
      #1;
      check_reset_values("midrst");
      beats.delete();
      m_done = 1'b0;
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
      expect_result("afterrst", 4, 4, 0);
      step(0, 0, 0, 0, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      check_model();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
